sub8_result_queue: RTL and testbench

- Downstream stage of the 8-bit ripple subtractor. It consumes the raw difference D and borrow-out Bout.
- Each captured result is converted to sign-magnitude form (magnitude, negative flag, zero flag).
- Results are buffered in a small FIFO and delivered to the next consumer over a valid/ready handshake.
- Decouples the combinational subtractor from a slower or stalling consumer.

---
 rtl/sub8_result_queue.sv | 182 ++++++++++++++++++
 tb/tb_sub8_result_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sub8_result_queue.sv
// sub8_result_queue: sign-magnitude result FIFO behind the 8-bit ripple subtractor.
// Converts each (D, Bout) pair to magnitude/negative/zero and queues it with
// valid/ready handshakes on both sides.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   d_in       raw difference D = A-B mod 256
//   bout_in    borrow-out, 1 when A<B
//   in_valid   producer offers a result
//   in_ready   queue not full (registered, independent of out_ready)
//   out_mag    head entry magnitude |A-B|
//   out_neg    head entry negative flag
//   out_zero   head entry zero flag
//   out_valid  queue not empty
//   out_ready  consumer takes the head entry
//   level      number of stored entries, 0..DEPTH
//
// Optional build macro SUB8_RESULT_QUEUE_STATS_EN adds:
//   push_count accepted pushes, saturating 16-bit
//   neg_count  accepted pushes with bout_in=1, saturating 16-bit

module sub8_result_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    d_in,
    input  logic          bout_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out_mag,
    output logic          out_neg,
    output logic          out_zero,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   level
`ifdef SUB8_RESULT_QUEUE_STATS_EN
    ,
    output logic [15:0]   neg_count,
    output logic [15:0]   push_count
`endif
);

    localparam int LW = AW + 1;

    localparam logic [AW:0]   LVL_FULL = LW'(DEPTH);
    localparam logic [AW:0]   LVL_ZERO = '0;
    localparam logic [AW:0]   LVL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Elaboration-time guard on the geometry.
    if ((DEPTH < 2) || (DEPTH != (1 << AW))) begin : g_bad_cfg
        $error("sub8_result_queue: DEPTH must be 2**AW and >= 2");
    end

    // ------------------------------------------------------------------
    // Storage (not reset; validity is tracked by level/pointers)
    // ------------------------------------------------------------------
    logic [7:0] mag_q  [DEPTH];
    logic       neg_q  [DEPTH];
    logic       zero_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q,  level_d;

    // ------------------------------------------------------------------
    // Capture-time conversion to sign-magnitude
    // ------------------------------------------------------------------
    logic [7:0] mag_in;
    logic       neg_in;
    logic       zero_in;

    always_comb begin
        mag_in  = d_in;
        neg_in  = bout_in;
        if (bout_in) begin
            // Two's-complement negate; D=0 with Bout=1 is kept as mag 0, neg 1.
            mag_in = (~d_in) + 8'd1;
        end
        zero_in = (mag_in == 8'd0);
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic push;
    logic pop;

    // Full blocks a push even when a pop lands on the same edge, so
    // in_ready never depends combinationally on out_ready.
    assign in_ready  = (level_q != LVL_FULL);
    assign out_valid = (level_q != LVL_ZERO);
    assign push      = in_valid  && in_ready;
    assign pop       = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Pointer and level next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Writes are gated by rst so a discarded push leaves storage alone.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mag_q[wr_ptr_q]  <= mag_in;
            neg_q[wr_ptr_q]  <= neg_in;
            zero_q[wr_ptr_q] <= zero_in;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead head entry
    // ------------------------------------------------------------------
    assign out_mag  = mag_q[rd_ptr_q];
    assign out_neg  = neg_q[rd_ptr_q];
    assign out_zero = zero_q[rd_ptr_q];
    assign level    = level_q;

`ifdef SUB8_RESULT_QUEUE_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------
    logic [15:0] push_cnt_q, push_cnt_d;
    logic [15:0] neg_cnt_q,  neg_cnt_d;

    always_comb begin
        push_cnt_d = push_cnt_q;
        neg_cnt_d  = neg_cnt_q;
        if (push && (push_cnt_q != 16'hFFFF)) begin
            push_cnt_d = push_cnt_q + 16'd1;
        end
        if (push && bout_in && (neg_cnt_q != 16'hFFFF)) begin
            neg_cnt_d = neg_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            push_cnt_q <= '0;
            neg_cnt_q  <= '0;
        end else begin
            push_cnt_q <= push_cnt_d;
            neg_cnt_q  <= neg_cnt_d;
        end
    end

    assign push_count = push_cnt_q;
    assign neg_count  = neg_cnt_q;
`endif

endmodule

// File: tb/tb_sub8_result_queue.sv
// tb_sub8_result_queue: directed and randomized checks of sub8_result_queue
// against a queue-based reference model.

module tb_sub8_result_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    d_in;
    logic          bout_in;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_mag;
    logic          out_neg;
    logic          out_zero;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   level;
`ifdef SUB8_RESULT_QUEUE_STATS_EN
    logic [15:0]   neg_count;
    logic [15:0]   push_count;
`endif

    sub8_result_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .bout_in   (bout_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_mag   (out_mag),
        .out_neg   (out_neg),
        .out_zero  (out_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
`ifdef SUB8_RESULT_QUEUE_STATS_EN
        ,
        .neg_count (neg_count),
        .push_count(push_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int mag;
        int neg;
        int zero;
    } ent_t;

    ent_t model_q[$];
    int   m_push_cnt = 0;
    int   m_neg_cnt  = 0;
    int   n_checks   = 0;
    int   n_err      = 0;
    bit   started    = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: update on each rising edge from the driven inputs.
    always @(posedge clk) begin
        bit do_push;
        bit do_pop;
        ent_t e;
        if (rst) begin
            model_q.delete();
            m_push_cnt = 0;
            m_neg_cnt  = 0;
        end else begin
            do_push = in_valid && (model_q.size() != DEPTH);
            do_pop  = out_ready && (model_q.size() != 0);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.mag  = bout_in ? ((256 - int'(d_in)) % 256) : int'(d_in);
                e.neg  = bout_in ? 1 : 0;
                e.zero = (e.mag == 0) ? 1 : 0;
                model_q.push_back(e);
                if (m_push_cnt < 65535) m_push_cnt++;
                if (bout_in && m_neg_cnt < 65535) m_neg_cnt++;
            end
        end
    end

    // Compare process: outputs are settled at the falling edge.
    always @(negedge clk) begin
        if (started) begin
            chk("level", 32'(level), 32'(model_q.size()));
            chk("in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
            chk("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
            if (model_q.size() != 0) begin
                chk("out_mag", 32'(out_mag), 32'(model_q[0].mag));
                chk("out_neg", 32'(out_neg), 32'(model_q[0].neg));
                chk("out_zero", 32'(out_zero), 32'(model_q[0].zero));
            end
`ifdef SUB8_RESULT_QUEUE_STATS_EN
            chk("push_count", 32'(push_count), 32'(m_push_cnt));
            chk("neg_count", 32'(neg_count), 32'(m_neg_cnt));
`endif
        end
    end

    // Drive at a falling edge, return at the next falling edge.
    task automatic step(input logic r, input logic iv, input logic [7:0] d,
                        input logic b, input logic ordy);
        rst       = r;
        in_valid  = iv;
        d_in      = d;
        bout_in   = b;
        out_ready = ordy;
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d, input logic b);
        step(1'b0, 1'b1, d, b, 1'b0);
    endtask

    task automatic pop1();
        step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    endtask

    task automatic head(input string nm, input int m, input int n, input int z);
        chk({nm, ".mag"}, 32'(out_mag), 32'(m));
        chk({nm, ".neg"}, 32'(out_neg), 32'(n));
        chk({nm, ".zero"}, 32'(out_zero), 32'(z));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        d_in      = 8'd0;
        bout_in   = 1'b0;
        out_ready = 1'b0;
        started   = 1;
        @(negedge clk);

        // Reset state
        chk("rst.level", 32'(level), 0);
        chk("rst.in_ready", 32'(in_ready), 1);
        chk("rst.out_valid", 32'(out_valid), 0);

        // Single push, show-ahead after one edge
        push(8'd240, 1'b0);
        chk("t1.valid", 32'(out_valid), 1);
        chk("t1.level", 32'(level), 1);
        head("t1", 240, 0, 0);
        pop1();
        chk("t1.empty", 32'(out_valid), 0);

        // Conversion and ordering
        push(8'd216, 1'b1);
        push(8'd0, 1'b0);
        push(8'd251, 1'b1);
        chk("t2.level", 32'(level), 3);
        head("t2a", 40, 1, 0);
        pop1();
        head("t2b", 0, 0, 1);
        pop1();
        head("t2c", 5, 1, 0);
        pop1();
        chk("t2.level0", 32'(level), 0);
        chk("t2.novalid", 32'(out_valid), 0);

        // Full queue rejects the fifth push
        push(8'd16, 1'b0);
        push(8'd241, 1'b1);
        push(8'd6, 1'b0);
        push(8'd6, 1'b0);
        chk("t3.full_ready", 32'(in_ready), 0);
        chk("t3.full_level", 32'(level), 4);
        push(8'd99, 1'b0);
        chk("t3.still4", 32'(level), 4);
        head("t3a", 16, 0, 0);
        pop1();
        head("t3b", 15, 1, 0);
        pop1();
        head("t3c", 6, 0, 0);
        pop1();
        head("t3d", 6, 0, 0);
        pop1();
        chk("t3.drained", 32'(out_valid), 0);
        pop1();
        chk("t3.no_underflow", 32'(level), 0);

        // Simultaneous push/pop at level 2 wraps pointers
        push(8'd90, 1'b0);
        push(8'd91, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 8'(100 + i), 1'b0, 1'b1);
            chk("t4.level", 32'(level), 2);
        end
        head("t4.head", 104, 0, 0);
        pop1();
        pop1();

        // Reset wins over push and pop
        push(8'd1, 1'b0);
        push(8'd2, 1'b0);
        push(8'd3, 1'b0);
        step(1'b1, 1'b1, 8'd4, 1'b0, 1'b1);
        chk("t5.level", 32'(level), 0);
        chk("t5.valid", 32'(out_valid), 0);
        chk("t5.ready", 32'(in_ready), 1);
        push(8'd33, 1'b0);
        head("t5.first", 33, 0, 0);
        pop1();

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            logic r;
            logic rdy;
            d   = 8'($urandom);
            if ($urandom_range(0, 15) == 0) d = 8'd0;
            r   = ($urandom_range(0, 79) == 0);
            rdy = (i % 200 < 100) ? ($urandom_range(0, 3) == 0)
                                  : ($urandom_range(0, 3) != 0);
            step(r, $urandom_range(0, 2) != 0, d, 1'($urandom), rdy);
        end

`ifdef SUB8_RESULT_QUEUE_STATS_EN
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'(10 + i), (i == 1 || i == 4 || i == 6), 1'b1);
        end
        chk("st.push", 32'(push_count), 8);
        chk("st.neg", 32'(neg_count), 3);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        chk("st.push_rst", 32'(push_count), 0);
        chk("st.neg_rst", 32'(neg_count), 0);
`endif

        step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        started = 0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
